// File: rtl/maxnet_host_if.sv
// rtl/maxnet_host_if.sv - host-side control, engine and result FIFO signals for maxnet_host
interface maxnet_host_if;
  logic        go;
  logic [3:0]  job_count;
  logic        start;
  logic        done;
  logic [31:0] result_in;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic        full;
  logic        busy;
  logic        batch_done;
  logic        timeout_err;

  modport master (
    output go, job_count, done, result_in, rd_en,
    input  start, rd_data, empty, full, busy, batch_done, timeout_err
  );

  modport slave (
    input  go, job_count, done, result_in, rd_en,
    output start, rd_data, empty, full, busy, batch_done, timeout_err
  );
endinterface

// File: rtl/maxnet_host.sv
// rtl/maxnet_host.sv - batch sequencer for a network engine with a first-word-fall-through result FIFO
// Optional WAIT abort enabled by defining MAXNET_HOST_TIMEOUT_EN.
module maxnet_host #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst,
  maxnet_host_if.slave host
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_FINISH} state_t;

  state_t        state_q;
  logic [3:0]    remaining_q;
  logic [31:0]   hold_q;
  logic          start_q;
  logic          busy_q;
  logic          batch_done_q;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          wr_fire;
  logic          rd_fire;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the held result.
  assign wr_fire    = (state_q == S_STORE) && (!fifo_full || host.rd_en);
  assign rd_fire    = host.rd_en && !fifo_empty;

  always_comb begin
    count_d = count_q;
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CW'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_ptr_q] <= hold_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

`ifdef MAXNET_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_err_q;
  assign host.timeout_err = timeout_err_q;
`else
  assign host.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      hold_q       <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
`ifdef MAXNET_HOST_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      start_q      <= 1'b0;
      batch_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host.go) begin
            busy_q      <= 1'b1;
            remaining_q <= host.job_count;
`ifdef MAXNET_HOST_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            if (host.job_count != 4'd0) begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
            end else begin
              state_q      <= S_FINISH;
              batch_done_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef MAXNET_HOST_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (host.done) begin
            hold_q  <= host.result_in;
            state_q <= S_STORE;
          end
`ifdef MAXNET_HOST_TIMEOUT_EN
          else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            remaining_q   <= '0;
            state_q       <= S_FINISH;
            batch_done_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
`endif
        end
        S_STORE: begin
          if (wr_fire) begin
            remaining_q <= remaining_q - 4'd1;
            if (remaining_q != 4'd1) begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
            end else begin
              state_q      <= S_FINISH;
              batch_done_q <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host.start      = start_q;
  assign host.busy       = busy_q;
  assign host.batch_done = batch_done_q;
  assign host.empty      = fifo_empty;
  assign host.full       = fifo_full;
  assign host.rd_data    = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_maxnet_host.sv
// tb/tb_maxnet_host.sv - scoreboard bench for maxnet_host (timeout case runs when MAXNET_HOST_TIMEOUT_EN is defined)
module tb_maxnet_host;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        go_r, rd_en_r, man_done, eng_done;
  logic [3:0]  job_r;
  logic [31:0] man_result, eng_result;

  maxnet_host_if host ();
  assign host.go        = go_r;
  assign host.job_count = job_r;
  assign host.rd_en     = rd_en_r;
  assign host.done      = eng_done | man_done;
  assign host.result_in = eng_done ? eng_result : man_result;

  maxnet_host #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (.clk(clk), .rst(rst), .host(host));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0, bd_cnt = 0, start_cyc = 0, bd_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] eng_res[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts strobes and compares every pop against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (host.start) begin start_cnt++; start_cyc = cyc; end
        if (host.batch_done) begin bd_cnt++; bd_cyc = cyc; end
        if (host.rd_en && !host.empty) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_unexpected actual=%0h expected=none", host.rd_data);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", host.rd_data, e);
          end
        end
      end
    end
  end

  // Engine: answers each start 5 cycles later while it has results queued.
  initial begin
    logic [31:0] r;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (host.start && eng_res.size() > 0) begin
        r = eng_res.pop_front();
        repeat (4) @(posedge clk);
        #1 eng_done = 1'b1; eng_result = r;
        @(posedge clk);
        #1 eng_done = 1'b0; eng_result = '0;
      end
    end
  end

  task automatic start_batch(input logic [3:0] n);
    @(posedge clk); #1 go_r = 1'b1; job_r = n;
    @(posedge clk); #1 go_r = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 rd_en_r = 1'b1;
    end
    @(posedge clk); #1 rd_en_r = 1'b0;
  endtask

  task automatic wait_bd(input int budget, input string name);
    int n0 = bd_cnt;
    int k = 0;
    while (bd_cnt == n0 && k < budget) begin
      @(negedge clk); #1 k++;
    end
    chk(name, 32'(bd_cnt != n0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; go_r = 1'b0; job_r = '0; rd_en_r = 1'b0; man_done = 1'b0; man_result = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_start", 32'(host.start), 0);
    chk("rst_busy", 32'(host.busy), 0);
    chk("rst_batch_done", 32'(host.batch_done), 0);
    chk("rst_timeout_err", 32'(host.timeout_err), 0);
    chk("rst_empty", 32'(host.empty), 1);
    chk("rst_full", 32'(host.full), 0);
    chk("rst_rd_data", host.rd_data, 0);

    // done held high through IDLE and ISSUE must be ignored
    @(posedge clk); #1 man_done = 1'b1; man_result = 32'hdead;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_done_busy", 32'(host.busy), 0);
    chk("idle_done_empty", 32'(host.empty), 1);
    @(posedge clk); #1 go_r = 1'b1; job_r = 4'd1;
    @(posedge clk); #1 go_r = 1'b0;
    @(posedge clk); #1 man_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("issue_done_empty", 32'(host.empty), 1);
    chk("issue_done_busy", 32'(host.busy), 1);
    exp_q.push_back(32'h55);
    @(posedge clk); #1 man_done = 1'b1; man_result = 32'h55;
    @(posedge clk); #1 man_done = 1'b0; man_result = '0;
    wait_bd(20, "manual_bd");
    pop_n(1);

    // three-job batch, leave two results in the FIFO
    start_cnt = 0; bd_cnt = 0;
    eng_res = '{32'd7, 32'd9, 32'd2};
    exp_q.push_back(32'd7); exp_q.push_back(32'd9); exp_q.push_back(32'd2);
    start_batch(4'd3);
    wait_bd(100, "b3_bd");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b3_starts", 32'(start_cnt), 3);
    chk("b3_bd_count", 32'(bd_cnt), 1);
    pop_n(1);

    // empty batch: no start, FIFO keeps 9 and 2
    start_cnt = 0;
    start_batch(4'd0);
    wait_bd(2, "b0_bd");
    chk("b0_starts", 32'(start_cnt), 0);
    chk("b0_empty", 32'(host.empty), 0);
    chk("b0_head", host.rd_data, 32'd9);
    pop_n(2);
    @(negedge clk);
    chk("b0_drained", 32'(host.empty), 1);

    // six jobs into a four-deep FIFO with no reads
    start_cnt = 0; bd_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      eng_res.push_back(32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
    end
    start_batch(4'd6);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("stall_full", 32'(host.full), 1);
    chk("stall_starts", 32'(start_cnt), 5);
    chk("stall_busy", 32'(host.busy), 1);
    pop_n(1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("resume_starts", 32'(start_cnt), 6);
    chk("resume_full", 32'(host.full), 1);
    chk("resume_no_bd", 32'(bd_cnt), 0);
    pop_n(5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b6_bd_count", 32'(bd_cnt), 1);
    chk("b6_empty", 32'(host.empty), 1);

    // reset while waiting on job 2 of 3
    start_cnt = 0;
    eng_res = '{32'd11, 32'd22, 32'd33};
    start_batch(4'd3);
    for (int k = 0; k < 50 && start_cnt < 2; k++) @(negedge clk);
    chk("rst_mid_reached", 32'(start_cnt), 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    eng_res.delete();
    @(negedge clk);
    chk("rst_mid_busy", 32'(host.busy), 0);
    chk("rst_mid_empty", 32'(host.empty), 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("late_done_empty", 32'(host.empty), 1);
    chk("late_done_busy", 32'(host.busy), 0);

`ifdef MAXNET_HOST_TIMEOUT_EN
    start_cnt = 0;
    start_batch(4'd2);
    wait_bd(40, "to_bd");
    chk("to_err", 32'(host.timeout_err), 1);
    chk("to_latency", 32'(bd_cyc - start_cyc), 11);
    chk("to_starts", 32'(start_cnt), 1);
    start_batch(4'd0);
    @(negedge clk);
    chk("to_cleared", 32'(host.timeout_err), 0);
    repeat (3) @(posedge clk);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxnet_host.md
MAXNET_HOST -- requirements
Module: maxnet_host

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning number of 32-bit result entries buffered (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning WAIT cycles before abort (used only with MAXNET_HOST_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port go  input  1  request to run a batch, sampled in IDLE only.
REQ-006 The block SHALL have port job_count  input  4  number of network runs in the batch, latched with go.
REQ-007 The block SHALL have port start  output  1  one-cycle run request to the network engine.
REQ-008 The block SHALL have port done  input  1  engine completion strobe.
REQ-009 The block SHALL have port result_in  input  32  engine result, valid in the cycle done is high.
REQ-010 The block SHALL have port rd_en  input  1  pop request for the result FIFO.
REQ-011 The block SHALL have port rd_data  output  32  FIFO head, first-word-fall-through; 0 when empty.
REQ-012 The block SHALL have port empty, full  output  1 each  FIFO status.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port batch_done  output  1  one-cycle pulse at batch end.
REQ-015 The block SHALL have port timeout_err  output  1  sticky abort flag.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, STORE, FINISH.
REQ-017 In IDLE, go=1 with job_count>0 SHALL latch job_count into a remaining-jobs counter and move to ISSUE; start SHALL be high in the cycle after go.
REQ-018 In IDLE, go=1 with job_count=0 SHALL move directly to FINISH; start SHALL NOT assert.
REQ-019 ISSUE SHALL last exactly one cycle with start=1, then move to WAIT; start SHALL be 0 in all other states.
REQ-020 In WAIT, done=1 SHALL capture result_in into a holding register and move to STORE; done in any other state SHALL be ignored.
REQ-021 In STORE, the held result SHALL be written when (!full || rd_en); the remaining counter SHALL decrement; the next state SHALL be ISSUE if the count is still nonzero, otherwise FINISH.
REQ-022 In STORE with full=1 and rd_en=0, the FSM SHALL stall with the result held and no data lost.
REQ-023 FINISH SHALL assert batch_done for one cycle and return to IDLE.
REQ-024 The FIFO SHALL use wrap-around read/write pointers; full and empty SHALL be derived from an occupancy count 0..FIFO_DEPTH.
REQ-025 rd_en on empty SHALL be ignored; simultaneous read and write SHALL leave occupancy unchanged, including when full.
REQ-026 FIFO contents SHALL persist across batches until popped; go SHALL NOT clear the FIFO.

Reset
REQ-027 With rst=1 at a clock edge, the block SHALL enter IDLE, clear the counters and FIFO pointers, and drive start=0, busy=0, batch_done=0, timeout_err=0, empty=1, full=0, rd_data=0.
REQ-028 rst SHALL take priority over all other inputs in every state, including mid-WAIT; a done arriving after reset SHALL be ignored.

Configuration
REQ-029 With macro MAXNET_HOST_TIMEOUT_EN defined, a WAIT cycle counter SHALL reset on entry to WAIT; reaching TIMEOUT_CYCLES without done SHALL set timeout_err, abandon remaining jobs, and go to FINISH.
REQ-030 With MAXNET_HOST_TIMEOUT_EN defined, timeout_err SHALL clear only on rst or on the next accepted go.
REQ-031 Without MAXNET_HOST_TIMEOUT_EN, WAIT SHALL last indefinitely, no timeout counter SHALL exist, and timeout_err SHALL be constant 0.

Verification
REQ-032 The bench SHALL cover: go with job_count=3, engine done 5 cycles after each start with results 7, 9, 2 -> exactly 3 start pulses, FIFO pops 7, 9, 2, one batch_done.
REQ-033 The bench SHALL cover: go with job_count=0 -> no start, batch_done 2 cycles after go, FIFO unchanged.
REQ-034 The bench SHALL cover: job_count=6, FIFO_DEPTH=4, no reads -> stall in STORE with full=1 after 4 stores; popping 1 value resumes; all 6 values are eventually read in order.
REQ-035 The bench SHALL cover: rst asserted in WAIT of job 2 of 3 -> IDLE next cycle, busy=0, empty=1; a late done does not write the FIFO.
REQ-036 The bench SHALL cover: with MAXNET_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=10 and done never asserted -> timeout_err=1 and batch_done pulse after 10 WAIT cycles; the next go clears timeout_err.
REQ-037 The bench SHALL cover: done held high while in IDLE and ISSUE -> no FIFO write and no state change.
